img_rsz_frm_arb: RTL and testbench

IMG_RSZ_FRM_ARB -- requirements
Module: img_rsz_frm_arb

---
 rtl/img_rsz_frm_arb_pkg.sv | 26 ++
 rtl/img_rsz_rr_pick.sv | 37 +++
 rtl/img_rsz_frm_arb.sv | 170 +++++++++++++++++
 tb/tb_img_rsz_frm_arb.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_rsz_frm_arb_pkg.sv
// ============================================================================
// Package  : ImgRszPkg
// Purpose  : Shared image-resizer types and widths, plus the frame arbiter
//            FSM state encoding.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package ImgRszPkg;

    localparam int IMG_WIDTH_IDX_W    = 10;
    localparam int IMG_HEIGHT_IDX_W   = 10;
    localparam int PXL_PRIM_COLOR_W   = 8;
    localparam int PXL_PRIM_COLOR_NUM = 3;

    typedef logic [PXL_PRIM_COLOR_NUM-1:0][PXL_PRIM_COLOR_W-1:0] FcRszPxlData_t;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_RUN   = 2'd1,
        ARB_DRAIN = 2'd2
    } ImgRszArbSt_t;

endpackage

`default_nettype wire

// File: rtl/img_rsz_rr_pick.sv
// ============================================================================
// Module   : img_rsz_rr_pick
// Purpose  : Combinational round-robin picker. Searches requests starting at
//            (lastIdx+1) mod SRC_NUM and reports the first one found.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module img_rsz_rr_pick #(
    parameter int SRC_NUM = 2,
    parameter int IDX_W   = 1
) (
    input  logic [SRC_NUM-1:0] req,
    input  logic [IDX_W-1:0]   lastIdx,
    output logic [IDX_W-1:0]   winIdx,
    output logic               found
);

    logic [IDX_W-1:0] w_cand;

    // Walk offsets from farthest to nearest so the nearest requester wins
    always_comb begin
        winIdx = '0;
        found  = 1'b0;
        w_cand = '0;
        for (int i = SRC_NUM; i >= 1; i--) begin
            w_cand = IDX_W'((int'(lastIdx) + i) % SRC_NUM);
            if (req[w_cand]) begin
                winIdx = w_cand;
                found  = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/img_rsz_frm_arb.sv
// ============================================================================
// Module   : img_rsz_frm_arb
// Purpose  : Frame-granular round-robin arbiter feeding one image resizer from
//            SRC_NUM pixel streams. Ownership is held for a whole frame and
//            released when the resizer reports completion.
// Options  : IMG_RSZ_FRM_ARB_STAT_EN adds per-source completed-frame counters.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module img_rsz_frm_arb
    import ImgRszPkg::*;
#(
    parameter int SRC_NUM = 2,
    parameter int CNT_W   = 16
) (
    input  logic                                                            Clk,
    input  logic                                                            Reset,
    input  logic [SRC_NUM-1:0][IMG_WIDTH_IDX_W-1:0]                         SrcImgWidth,
    input  logic [SRC_NUM-1:0][IMG_HEIGHT_IDX_W-1:0]                        SrcImgHeight,
    input  logic [SRC_NUM-1:0][PXL_PRIM_COLOR_NUM-1:0][PXL_PRIM_COLOR_W-1:0] SrcPxlData,
    input  logic [SRC_NUM-1:0][IMG_WIDTH_IDX_W-1:0]                         SrcPxlX,
    input  logic [SRC_NUM-1:0][IMG_HEIGHT_IDX_W-1:0]                        SrcPxlY,
    input  logic [SRC_NUM-1:0]                                              SrcPxlVld,
    output logic [SRC_NUM-1:0]                                              SrcPxlRdy,
    output logic [IMG_WIDTH_IDX_W-1:0]                                      ImgWidth,
    output logic [IMG_HEIGHT_IDX_W-1:0]                                     ImgHeight,
    output logic [PXL_PRIM_COLOR_NUM-1:0][PXL_PRIM_COLOR_W-1:0]             PxlData,
    output logic [IMG_WIDTH_IDX_W-1:0]                                      PxlX,
    output logic [IMG_HEIGHT_IDX_W-1:0]                                     PxlY,
    output logic                                                            PxlVld,
    input  logic                                                            PxlRdy,
    input  logic                                                            RszImgComp,
    output logic [SRC_NUM-1:0]                                              Gnt,
    output logic                                                            Busy
`ifdef IMG_RSZ_FRM_ARB_STAT_EN
    ,
    output logic [SRC_NUM-1:0][CNT_W-1:0]                                   FrmCnt
`endif
);

    localparam int GNT_W = (SRC_NUM > 1) ? $clog2(SRC_NUM) : 1;

    ImgRszArbSt_t                r_state;
    ImgRszArbSt_t                w_nxtState;
    logic [GNT_W-1:0]            r_gntIdx;
    logic [GNT_W-1:0]            r_lastIdx;
    logic [GNT_W-1:0]            w_winIdx;
    logic                        w_found;
    logic [IMG_WIDTH_IDX_W-1:0]  r_hCnt;
    logic [IMG_HEIGHT_IDX_W-1:0] r_vCnt;
    logic [IMG_WIDTH_IDX_W-1:0]  r_imgWidth;
    logic [IMG_HEIGHT_IDX_W-1:0] r_imgHeight;
    logic                        w_beat;
    logic                        w_hLast;
    logic                        w_vLast;
    FcRszPxlData_t               w_ownPxl;

    img_rsz_rr_pick #(
        .SRC_NUM (SRC_NUM),
        .IDX_W   (GNT_W)
    ) u_pick (
        .req     (SrcPxlVld),
        .lastIdx (r_lastIdx),
        .winIdx  (w_winIdx),
        .found   (w_found)
    );

    assign w_beat  = (r_state == ARB_RUN) & SrcPxlVld[r_gntIdx] & PxlRdy;
    assign w_hLast = (r_hCnt == r_imgWidth  - IMG_WIDTH_IDX_W'(1));
    assign w_vLast = (r_vCnt == r_imgHeight - IMG_HEIGHT_IDX_W'(1));

    // Payload always follows the registered owner; validity is gated below
    assign w_ownPxl  = SrcPxlData[r_gntIdx];
    assign PxlData   = w_ownPxl;
    assign PxlX      = SrcPxlX[r_gntIdx];
    assign PxlY      = SrcPxlY[r_gntIdx];
    assign ImgWidth  = r_imgWidth;
    assign ImgHeight = r_imgHeight;

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_nxtState;
        end
    end

    // Next-state and handshake/grant outputs; everything is forced low in reset
    always_comb begin
        w_nxtState = r_state;
        Gnt        = '0;
        Busy       = 1'b0;
        PxlVld     = 1'b0;
        SrcPxlRdy  = '0;
        case (r_state)
            ARB_IDLE: begin
                if (w_found) begin
                    w_nxtState = ARB_RUN;
                end
            end
            ARB_RUN: begin
                if (RszImgComp) begin
                    w_nxtState = ARB_IDLE;
                end else if (w_beat && w_hLast && w_vLast) begin
                    w_nxtState = ARB_DRAIN;
                end
            end
            ARB_DRAIN: begin
                if (RszImgComp) begin
                    w_nxtState = ARB_IDLE;
                end
            end
            default: w_nxtState = ARB_IDLE;
        endcase
        if (!Reset && (r_state != ARB_IDLE)) begin
            Busy          = 1'b1;
            Gnt[r_gntIdx] = 1'b1;
            if (r_state == ARB_RUN) begin
                PxlVld              = SrcPxlVld[r_gntIdx];
                SrcPxlRdy[r_gntIdx] = PxlRdy;
            end
        end
    end

    // Grant capture, frame geometry latch, beat counters and last-owner memory
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_gntIdx    <= '0;
            r_lastIdx   <= GNT_W'(SRC_NUM - 1);
            r_hCnt      <= '0;
            r_vCnt      <= '0;
            r_imgWidth  <= '1;
            r_imgHeight <= '1;
        end else begin
            if ((r_state == ARB_IDLE) && w_found) begin
                r_gntIdx    <= w_winIdx;
                r_imgWidth  <= SrcImgWidth[w_winIdx];
                r_imgHeight <= SrcImgHeight[w_winIdx];
                r_hCnt      <= '0;
                r_vCnt      <= '0;
            end else if (w_beat) begin
                if (w_hLast) begin
                    r_hCnt <= '0;
                    r_vCnt <= r_vCnt + IMG_HEIGHT_IDX_W'(1);
                end else begin
                    r_hCnt <= r_hCnt + IMG_WIDTH_IDX_W'(1);
                end
            end
            if ((r_state != ARB_IDLE) && RszImgComp) begin
                r_lastIdx <= r_gntIdx;
            end
        end
    end

`ifdef IMG_RSZ_FRM_ARB_STAT_EN
    // Completed-frame counters; aborted frames never reach DRAIN so never count
    always_ff @(posedge Clk) begin
        if (Reset) begin
            FrmCnt <= '0;
        end else if ((r_state == ARB_DRAIN) && RszImgComp) begin
            FrmCnt[r_gntIdx] <= FrmCnt[r_gntIdx] + CNT_W'(1);
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_img_rsz_frm_arb.sv
// ============================================================================
// Module   : tb_img_rsz_frm_arb
// Purpose  : Self-checking bench for img_rsz_frm_arb (two sources).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_img_rsz_frm_arb;
    import ImgRszPkg::*;

    localparam int N     = 2;
    localparam int CNT_W = 16;

    logic Clk = 1'b0;
    logic Reset;
    logic [N-1:0][IMG_WIDTH_IDX_W-1:0]                          SrcImgWidth;
    logic [N-1:0][IMG_HEIGHT_IDX_W-1:0]                         SrcImgHeight;
    logic [N-1:0][PXL_PRIM_COLOR_NUM-1:0][PXL_PRIM_COLOR_W-1:0] SrcPxlData;
    logic [N-1:0][IMG_WIDTH_IDX_W-1:0]                          SrcPxlX;
    logic [N-1:0][IMG_HEIGHT_IDX_W-1:0]                         SrcPxlY;
    logic [N-1:0]                                               SrcPxlVld;
    logic [N-1:0]                                               SrcPxlRdy;
    logic [IMG_WIDTH_IDX_W-1:0]                                 ImgWidth;
    logic [IMG_HEIGHT_IDX_W-1:0]                                ImgHeight;
    logic [PXL_PRIM_COLOR_NUM-1:0][PXL_PRIM_COLOR_W-1:0]        PxlData;
    logic [IMG_WIDTH_IDX_W-1:0]                                 PxlX;
    logic [IMG_HEIGHT_IDX_W-1:0]                                PxlY;
    logic                                                       PxlVld;
    logic                                                       PxlRdy;
    logic                                                       RszImgComp;
    logic [N-1:0]                                               Gnt;
    logic                                                       Busy;
`ifdef IMG_RSZ_FRM_ARB_STAT_EN
    logic [N-1:0][CNT_W-1:0]                                    FrmCnt;
`endif

    img_rsz_frm_arb #(.SRC_NUM(N), .CNT_W(CNT_W)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .SrcImgWidth  (SrcImgWidth),
        .SrcImgHeight (SrcImgHeight),
        .SrcPxlData   (SrcPxlData),
        .SrcPxlX      (SrcPxlX),
        .SrcPxlY      (SrcPxlY),
        .SrcPxlVld    (SrcPxlVld),
        .SrcPxlRdy    (SrcPxlRdy),
        .ImgWidth     (ImgWidth),
        .ImgHeight    (ImgHeight),
        .PxlData      (PxlData),
        .PxlX         (PxlX),
        .PxlY         (PxlY),
        .PxlVld       (PxlVld),
        .PxlRdy       (PxlRdy),
        .RszImgComp   (RszImgComp),
        .Gnt          (Gnt),
        .Busy         (Busy)
`ifdef IMG_RSZ_FRM_ARB_STAT_EN
        ,
        .FrmCnt       (FrmCnt)
`endif
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int src;
        int x;
        int y;
        int w;
        int h;
        bit last;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   beats;
    int   srcW[N], srcH[N], srcX[N], srcY[N], srcFrames[N], expFrm[N];
    bit   drainChk = 0, idleChk = 0, compNext = 0, toggle = 0;
    int   drainSrc = 0;

    function automatic logic [N-1:0] oh(input int s);
        logic [N-1:0] v;
        v    = '0;
        v[s] = 1'b1;
        return v;
    endfunction

    function automatic FcRszPxlData_t pix(input int s, input int x, input int y);
        FcRszPxlData_t d;
        d[0] = 8'(s * 37 + x);
        d[1] = 8'(y * 11 + 1);
        d[2] = 8'(x ^ y ^ (s << 4));
        return d;
    endfunction

    task automatic drive_srcs();
        for (int s = 0; s < N; s++) begin
            SrcImgWidth[s]  = IMG_WIDTH_IDX_W'(srcW[s]);
            SrcImgHeight[s] = IMG_HEIGHT_IDX_W'(srcH[s]);
            SrcPxlX[s]      = IMG_WIDTH_IDX_W'(srcX[s]);
            SrcPxlY[s]      = IMG_HEIGHT_IDX_W'(srcY[s]);
            SrcPxlData[s]   = pix(s, srcX[s], srcY[s]);
            SrcPxlVld[s]    = (srcFrames[s] > 0);
        end
    endtask

    task automatic start_frame(input int s, input int w, input int h, input int frames);
        srcW[s] = w; srcH[s] = h; srcX[s] = 0; srcY[s] = 0; srcFrames[s] = frames;
        drive_srcs();
    endtask

    task automatic push_frame(input int s, input int w, input int h);
        exp_t e;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                e.src = s; e.x = x; e.y = y; e.w = w; e.h = h;
                e.last = (x == w - 1) && (y == h - 1);
                q.push_back(e);
            end
        end
    endtask

    task automatic clear_model();
        q.delete();
        drainChk = 0; idleChk = 0; compNext = 0; RszImgComp = 1'b0;
        for (int s = 0; s < N; s++) begin
            srcFrames[s] = 0;
            expFrm[s]    = 0;
        end
        drive_srcs();
    endtask

    // One clock: sample at negedge, then update source models after the edge
    task automatic cycle();
        logic [N-1:0] hs;
        exp_t e;
        @(negedge Clk);
        hs = SrcPxlVld & SrcPxlRdy;
        if (q.size() > 0) begin
            checks++;
            if ((SrcPxlRdy & ~oh(q[0].src)) !== '0) begin
                errors++;
                $display("FAIL loser_rdy: SrcPxlRdy=%b owner=%0d", SrcPxlRdy, q[0].src);
            end
        end
        if (drainChk) begin
            checks++;
            if (Busy !== 1'b1 || PxlVld !== 1'b0 || SrcPxlRdy !== '0 || Gnt !== oh(drainSrc)) begin
                errors++;
                $display("FAIL drain_state: Busy=%b PxlVld=%b SrcPxlRdy=%b Gnt=%b, required 1 0 00 %b",
                         Busy, PxlVld, SrcPxlRdy, Gnt, oh(drainSrc));
            end
            drainChk = 0;
            idleChk  = 1;
        end else if (idleChk) begin
            checks++;
            if (Busy !== 1'b0 || Gnt !== '0) begin
                errors++;
                $display("FAIL idle_after_comp: Busy=%b Gnt=%b, required 0 00", Busy, Gnt);
            end
            idleChk = 0;
        end
        if (PxlVld === 1'b1 && PxlRdy === 1'b1) begin
            beats++;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: Gnt=%b PxlX=%0d PxlY=%0d", Gnt, PxlX, PxlY);
            end else begin
                e = q.pop_front();
                if (Gnt !== oh(e.src) || PxlX !== IMG_WIDTH_IDX_W'(e.x) ||
                    PxlY !== IMG_HEIGHT_IDX_W'(e.y) || PxlData !== pix(e.src, e.x, e.y) ||
                    ImgWidth !== IMG_WIDTH_IDX_W'(e.w) || ImgHeight !== IMG_HEIGHT_IDX_W'(e.h)) begin
                    errors++;
                    $display("FAIL beat: got Gnt=%b X=%0d Y=%0d D=%h W=%0d H=%0d, required Gnt=%b X=%0d Y=%0d D=%h W=%0d H=%0d",
                             Gnt, PxlX, PxlY, PxlData, ImgWidth, ImgHeight,
                             oh(e.src), e.x, e.y, pix(e.src, e.x, e.y), e.w, e.h);
                end
                if (e.last) begin
                    drainChk = 1;
                    drainSrc = e.src;
                    compNext = 1;
                    expFrm[e.src]++;
                end
            end
        end
        @(posedge Clk);
        #1;
        RszImgComp = compNext;
        compNext   = 0;
        for (int s = 0; s < N; s++) begin
            if (hs[s]) begin
                if (srcX[s] == srcW[s] - 1) begin
                    srcX[s] = 0;
                    if (srcY[s] == srcH[s] - 1) begin
                        srcY[s] = 0;
                        srcFrames[s]--;
                    end else begin
                        srcY[s]++;
                    end
                end else begin
                    srcX[s]++;
                end
            end
        end
        PxlRdy = toggle ? ~PxlRdy : 1'b1;
        drive_srcs();
    endtask

    task automatic run_frames(input int budget, input string tag);
        int n = 0;
        while ((q.size() > 0 || drainChk || idleChk) && n < budget) begin
            cycle();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s_timeout: %0d beats pending after %0d cycles, required 0", tag, q.size(), n);
            q.delete(); drainChk = 0; idleChk = 0;
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        clear_model();
        start_frame(0, 2, 2, 1);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        checks++;
        if (Gnt !== '0 || Busy !== 1'b0 || PxlVld !== 1'b0 || SrcPxlRdy !== '0) begin
            errors++;
            $display("FAIL reset_outputs: Gnt=%b Busy=%b PxlVld=%b SrcPxlRdy=%b, required all 0",
                     Gnt, Busy, PxlVld, SrcPxlRdy);
        end
        @(posedge Clk); #1;
        Reset = 1'b0;
        srcFrames[0] = 0;
        drive_srcs();
        @(negedge Clk);
        checks++;
        if (ImgWidth !== '1 || ImgHeight !== '1 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_dims: ImgWidth=%h ImgHeight=%h Busy=%b, required 3ff 3ff 0",
                     ImgWidth, ImgHeight, Busy);
        end
        @(posedge Clk); #1;
    endtask

    task automatic test_single();
        beats = 0;
        start_frame(0, 4, 2, 1);
        push_frame(0, 4, 2);
        run_frames(100, "single");
        checks++;
        if (beats !== 8) begin
            errors++;
            $display("FAIL single_beats: got %0d, required 8", beats);
        end
    endtask

    task automatic test_back_to_back();
        beats = 0;
        Reset = 1'b1;
        clear_model();
        start_frame(0, 2, 2, 2);
        start_frame(1, 2, 2, 1);
        push_frame(0, 2, 2);
        push_frame(1, 2, 2);
        push_frame(0, 2, 2);
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        run_frames(200, "back_to_back");
        checks++;
        if (beats !== 12) begin
            errors++;
            $display("FAIL b2b_beats: got %0d, required 12", beats);
        end
    endtask

    task automatic test_rdy_toggle();
        beats  = 0;
        toggle = 1;
        PxlRdy = 1'b1;
        start_frame(1, 3, 3, 1);
        push_frame(1, 3, 3);
        run_frames(200, "toggle");
        toggle = 0;
        PxlRdy = 1'b1;
        checks++;
        if (beats !== 9) begin
            errors++;
            $display("FAIL toggle_beats: got %0d, required 9", beats);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        beats = 0;
        start_frame(0, 4, 4, 1);
        push_frame(0, 4, 4);
        while (beats < 5 && n < 100) begin
            cycle();
            n++;
        end
        checks++;
        if (beats !== 5) begin
            errors++;
            $display("FAIL mid_reach: got %0d beats, required 5", beats);
        end
        Reset = 1'b1;
        clear_model();
        @(negedge Clk);
        checks++;
        if (Gnt !== '0 || Busy !== 1'b0 || PxlVld !== 1'b0 || SrcPxlRdy !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: Gnt=%b Busy=%b PxlVld=%b SrcPxlRdy=%b, required all 0",
                     Gnt, Busy, PxlVld, SrcPxlRdy);
        end
        @(posedge Clk); #1;
        Reset = 1'b0;
        @(negedge Clk);
        checks++;
        if (Busy !== 1'b0 || ImgWidth !== '1 || ImgHeight !== '1) begin
            errors++;
            $display("FAIL mid_after_reset: Busy=%b ImgWidth=%h ImgHeight=%h, required 0 3ff 3ff",
                     Busy, ImgWidth, ImgHeight);
        end
        @(posedge Clk); #1;
        beats = 0;
        start_frame(1, 1, 2, 1);
        push_frame(1, 1, 2);
        run_frames(100, "mid_src1");
        checks++;
        if (beats !== 2) begin
            errors++;
            $display("FAIL mid_src1_beats: got %0d, required 2", beats);
        end
    endtask

    task automatic test_abort();
        int n = 0;
        beats = 0;
        start_frame(0, 4, 4, 1);
        push_frame(0, 4, 4);
        while (beats < 2 && n < 100) begin
            cycle();
            n++;
        end
        RszImgComp = 1'b1;
        cycle();
        srcFrames[0] = 0;
        drive_srcs();
        q.delete();
        @(negedge Clk);
        checks++;
        if (Busy !== 1'b0 || Gnt !== '0 || beats !== 3) begin
            errors++;
            $display("FAIL abort: Busy=%b Gnt=%b beats=%0d, required 0 00 3", Busy, Gnt, beats);
        end
`ifdef IMG_RSZ_FRM_ARB_STAT_EN
        checks++;
        if (FrmCnt[0] !== CNT_W'(expFrm[0]) || FrmCnt[1] !== CNT_W'(expFrm[1])) begin
            errors++;
            $display("FAIL abort_frmcnt: got %0d/%0d, required %0d/%0d",
                     FrmCnt[0], FrmCnt[1], expFrm[0], expFrm[1]);
        end
`endif
        @(posedge Clk); #1;
    endtask

    task automatic test_one_pixel();
        beats = 0;
        start_frame(0, 1, 1, 1);
        push_frame(0, 1, 1);
        run_frames(50, "one_pixel");
        checks++;
        if (beats !== 1) begin
            errors++;
            $display("FAIL one_pixel_beats: got %0d, required 1", beats);
        end
`ifdef IMG_RSZ_FRM_ARB_STAT_EN
        checks++;
        if (FrmCnt[0] !== CNT_W'(expFrm[0]) || FrmCnt[0] !== CNT_W'(1)) begin
            errors++;
            $display("FAIL one_pixel_frmcnt: got %0d, required %0d", FrmCnt[0], expFrm[0]);
        end
`endif
    endtask

    initial begin
        Reset      = 1'b1;
        PxlRdy     = 1'b1;
        RszImgComp = 1'b0;
        for (int s = 0; s < N; s++) begin
            srcW[s] = 1; srcH[s] = 1; srcX[s] = 0; srcY[s] = 0;
            srcFrames[s] = 0; expFrm[s] = 0;
        end
        drive_srcs();
        test_reset();
        test_single();
        test_back_to_back();
        test_rdy_toggle();
        test_reset_mid();
        test_abort();
        test_one_pixel();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
